led_blink_ctrl: RTL and testbench

Multi-channel LED blink controller that sits directly downstream of the millisecond timer. It consumes the timer's free-running 16-bit ms count and drives the timer's enable. Each channel has a softcore-programmable half-period in ms and toggles its LED each time that many ms elapse. The register port is a simple write/read strobe interface driven by the MMIO bridge.

---
 rtl/led_blink_pkg.sv | 14 +
 rtl/led_blink_ctrl_if.sv | 17 +
 rtl/led_blink_channel.sv | 39 +++
 rtl/led_blink_ctrl.sv | 77 +++++++
 tb/tb_led_blink_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/led_blink_pkg.sv
// Shared constants and helpers for the LED blink controller: register map
// layout and the address-width calculation used by the top and its bus.
package led_blink_pkg;

    localparam int CTRL_ADDR   = 0;
    localparam int PERIOD_BASE = 1;
    localparam int CTRL_EN_BIT = 0;

    // One CTRL register plus one PERIOD register per channel.
    function automatic int addr_w(input int n_led);
        return $clog2(n_led + 1);
    endfunction

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Register strobe port between the MMIO bridge (master) and the blink controller (slave).
interface led_blink_ctrl_if #(
    parameter int MS_W   = 16,
    parameter int ADDR_W = 3
);
    // Strobe protocol, no backpressure: a write is accepted on every cycle
    // wr_en is high; rd_data always shows the register at rd_addr of the
    // previous cycle.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MS_W-1:0]   wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [MS_W-1:0]   rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/led_blink_channel.sv
// One blink channel: half-period register, last-toggle ms stamp and the LED flop.
module led_blink_channel #(
    parameter int MS_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [MS_W-1:0] ms,
    input  logic            enable,
    input  logic            wr_hit,
    input  logic [MS_W-1:0] wr_data,
    output logic            led,
    output logic [MS_W-1:0] period
);

    logic [MS_W-1:0] stamp;
    logic [MS_W-1:0] elapsed;
    logic            due;

    // Modular subtraction keeps the comparison correct across ms wrap.
    assign elapsed = ms - stamp;
    assign due     = (period != '0) && enable && (elapsed >= period);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period <= '0;
            stamp  <= '0;
            led    <= 1'b0;
        end else if (wr_hit) begin
            // A programming write overrides any toggle due in the same cycle.
            period <= wr_data;
            stamp  <= ms;
            led    <= (wr_data != '0);
        end else if (due) begin
            stamp  <= ms;
            led    <= ~led;
        end
    end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: CTRL register, address decode, read mux
// and one led_blink_channel per LED, paced by the external ms timer.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int N_LED = 4,
    parameter int MS_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MS_W-1:0]  ms,
    output logic             timer_en,
    output logic [N_LED-1:0] led,
    led_blink_ctrl_if.slave  bus
);

    localparam int ADDR_W = addr_w(N_LED);

    logic             ctrl_en;
    logic [N_LED-1:0] wr_hit;
    logic [MS_W-1:0]  period_q [N_LED];
    logic [MS_W-1:0]  rd_next;
    logic             ctrl_wr;

    assign ctrl_wr  = bus.wr_en && (bus.wr_addr == ADDR_W'(CTRL_ADDR));
    assign timer_en = ctrl_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_en <= bus.wr_data[CTRL_EN_BIT];
        end
    end

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_LED; i++) begin
            wr_hit[i] = bus.wr_en && (bus.wr_addr == ADDR_W'(PERIOD_BASE + i));
        end
    end

    // Channels see the enable from before any same-cycle CTRL write.
    for (genvar g = 0; g < N_LED; g++) begin : g_chan
        led_blink_channel #(.MS_W(MS_W)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .ms      (ms),
            .enable  (ctrl_en),
            .wr_hit  (wr_hit[g]),
            .wr_data (bus.wr_data),
            .led     (led[g]),
            .period  (period_q[g])
        );
    end

    always_comb begin
        rd_next = '0;
        if (bus.rd_addr == ADDR_W'(CTRL_ADDR)) begin
            rd_next[CTRL_EN_BIT] = ctrl_en;
        end
        for (int i = 0; i < N_LED; i++) begin
            if (bus.rd_addr == ADDR_W'(PERIOD_BASE + i)) begin
                rd_next = period_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: blink, wrap, off/invalid, freeze,
// write/toggle collisions and asynchronous reset.
module tb_led_blink_ctrl;
    import led_blink_pkg::*;

    localparam int N_LED  = 4;
    localparam int MS_W   = 16;
    localparam int ADDR_W = addr_w(N_LED);

    logic             clk;
    logic             rst;
    logic [MS_W-1:0]  ms;
    logic             timer_en;
    logic [N_LED-1:0] led;

    int n_vec = 0;
    int n_err = 0;

    led_blink_ctrl_if #(.MS_W(MS_W), .ADDR_W(ADDR_W)) bus ();

    led_blink_ctrl #(.N_LED(N_LED), .MS_W(MS_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ms       (ms),
        .timer_en (timer_en),
        .led      (led),
        .bus      (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks: inputs change only while clk is low
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reg_write(input int addr, input logic [MS_W-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = data;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic read_check(input string tag, input int addr, input logic [MS_W-1:0] exp);
        bus.rd_addr = ADDR_W'(addr);
        step();
        check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic advance_ms(input int n);
        for (int k = 0; k < n; k++) begin
            ms = ms + 1'b1;
            repeat (8) step();
        end
    endtask

    task automatic set_ms(input logic [MS_W-1:0] v);
        ms = v;
        step();
    endtask

    initial begin
        rst         = 1'b0;
        ms          = 16'd100;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_led", 32'(led), 32'h0);
        check("rst_timer_en", 32'(timer_en), 32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        rst = 1'b1;
        step();

        // basic blink, period 5 from ms=100
        reg_write(CTRL_ADDR, 16'h0001);
        check("en_timer_en", 32'(timer_en), 32'h1);
        reg_write(PERIOD_BASE + 0, 16'd5);
        check("blink_start", 32'(led), 32'b0001);
        advance_ms(4);
        check("blink_ms104", 32'(led), 32'b0001);
        advance_ms(1);
        check("blink_ms105", 32'(led), 32'b0000);
        advance_ms(5);
        check("blink_ms110", 32'(led), 32'b0001);
        advance_ms(5);
        check("blink_ms115", 32'(led), 32'b0000);
        read_check("rd_period0", PERIOD_BASE + 0, 16'd5);
        read_check("rd_ctrl", CTRL_ADDR, 16'h0001);
        reg_write(PERIOD_BASE + 0, 16'd0);

        // wrap-around on channel 1
        ms = 16'd65533;
        reg_write(PERIOD_BASE + 1, 16'd5);
        check("wrap_start", 32'(led), 32'b0010);
        advance_ms(2);
        check("wrap_ms65535", 32'(led), 32'b0010);
        advance_ms(2);
        check("wrap_ms1", 32'(led), 32'b0010);
        advance_ms(1);
        check("wrap_ms2", 32'(led), 32'b0000);
        check("wrap_ms_value", 32'(ms), 32'd2);
        reg_write(PERIOD_BASE + 1, 16'd0);

        // period zero and invalid address
        reg_write(PERIOD_BASE + 2, 16'd3);
        check("p2_start", 32'(led), 32'b0100);
        advance_ms(3);
        check("p2_ms5", 32'(led), 32'b0000);
        advance_ms(3);
        check("p2_ms8", 32'(led), 32'b0100);
        reg_write(PERIOD_BASE + 2, 16'd0);
        check("p2_off", 32'(led), 32'b0000);
        advance_ms(20);
        check("p2_off_20ms", 32'(led), 32'b0000);
        read_check("rd_period2_zero", PERIOD_BASE + 2, 16'd0);
        reg_write(N_LED + 1, 16'h1234);
        read_check("rd_invalid5", N_LED + 1, 16'd0);
        read_check("rd_invalid7", 7, 16'd0);
        read_check("rd_ctrl_after_inv", CTRL_ADDR, 16'h0001);

        // disable freeze: ms=28 here
        reg_write(PERIOD_BASE + 0, 16'd4);
        check("frz_start", 32'(led), 32'b0001);
        reg_write(CTRL_ADDR, 16'h0000);
        check("frz_timer_en", 32'(timer_en), 32'h0);
        advance_ms(10);
        check("frz_held", 32'(led), 32'b0001);
        reg_write(CTRL_ADDR, 16'h0001);
        check("frz_ren_cycle", 32'(led), 32'b0001);
        check("frz_ren_timer_en", 32'(timer_en), 32'h1);
        step();
        check("frz_resume", 32'(led), 32'b0000);

        // write/toggle collision: stamp 38, period 4
        set_ms(16'd42);
        check("col_pre", 32'(led), 32'b0001);
        ms = 16'd46;
        reg_write(PERIOD_BASE + 0, 16'd7);
        check("col_write_wins", 32'(led), 32'b0001);
        set_ms(16'd52);
        check("col_ms52", 32'(led), 32'b0001);
        set_ms(16'd53);
        check("col_ms53", 32'(led), 32'b0000);
        // CTRL write in a due cycle uses the old enable
        ms = 16'd60;
        reg_write(CTRL_ADDR, 16'h0000);
        check("ctrl_col_toggle", 32'(led), 32'b0001);
        set_ms(16'd67);
        check("ctrl_col_frozen", 32'(led), 32'b0001);
        reg_write(CTRL_ADDR, 16'h0001);
        step();
        check("ctrl_col_resume", 32'(led), 32'b0000);

        // async reset mid-run with led=1011
        reg_write(PERIOD_BASE + 0, 16'd100);
        reg_write(PERIOD_BASE + 1, 16'd100);
        reg_write(PERIOD_BASE + 3, 16'd100);
        check("ar_pattern", 32'(led), 32'b1011);
        read_check("ar_rd_period0", PERIOD_BASE + 0, 16'd100);
        #2 rst = 1'b0;
        #1;
        check("ar_led", 32'(led), 32'h0);
        check("ar_timer_en", 32'(timer_en), 32'h0);
        check("ar_rd_data", 32'(bus.rd_data), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        read_check("ar_rd_period0_post", PERIOD_BASE + 0, 16'd0);
        read_check("ar_rd_period3_post", PERIOD_BASE + 3, 16'd0);
        read_check("ar_rd_ctrl_post", CTRL_ADDR, 16'h0000);
        advance_ms(5);
        check("ar_led_stays_off", 32'(led), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
